// File: rtl/uio_bus_arbiter.sv
// Two-requester round-robin arbiter for the shared bidirectional uio pad bank.
// Bounds each drive burst, forces released-bus turnaround cycles, and samples the pads while idle.
module uio_bus_arbiter #(
   parameter int WIDTH       = 8,
   parameter int MAX_BURST   = 16,
   parameter int TURN_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] pad_in,
   output logic [1:0]       gnt,
   output logic [WIDTH-1:0] pad_out,
   output logic [WIDTH-1:0] pad_oe,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid
);

   localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
   localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
   localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      TURN  = 2'd2
   } state_t;

   state_t        state;
   logic          owner;
   logic          ptr;
   logic [BW-1:0] burst_cnt;
   logic [TW-1:0] turn_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= 1'b0;
         ptr       <= 1'b0;
         burst_cnt <= '0;
         turn_cnt  <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
      end else begin
         rx_valid <= (state == IDLE);
         case (state)
            IDLE: begin
               rx_data <= pad_in;
               if (req != 2'b00) begin
                  owner     <= (req == 2'b11) ? ptr : req[1];
                  burst_cnt <= '0;
                  state     <= DRIVE;
               end
            end
            DRIVE: begin
               // A release and a timeout on the same edge take one path, so ptr moves once.
               if (!req[owner] || burst_cnt == BURST_LAST) begin
                  state    <= TURN;
                  ptr      <= ~owner;
                  turn_cnt <= '0;
               end else begin
                  burst_cnt <= burst_cnt + 1'b1;
               end
            end
            TURN: begin
               if (turn_cnt == TURN_LAST) begin
                  state <= IDLE;
               end else begin
                  turn_cnt <= turn_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode straight from state so an async reset releases the pads immediately.
   assign gnt     = (state == DRIVE) ? (owner ? 2'b10 : 2'b01) : 2'b00;
   assign pad_oe  = {WIDTH{state == DRIVE}};
   assign pad_out = (state == DRIVE) ? (owner ? data1 : data0) : '0;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Randomized bench for uio_bus_arbiter against a burst/gap level reference model.
module tb_uio_bus_arbiter;

   localparam int W  = 8;
   localparam int MB = 4;
   localparam int TC = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   req;
   logic [W-1:0] data0, data1, pad_in;
   logic [1:0]   gnt;
   logic [W-1:0] pad_out, pad_oe, rx_data;
   logic         rx_valid;

   int total = 0;
   int bad   = 0;

   // model: m_own = -1 when nobody drives, m_gap = released-bus cycles still owed
   int           m_own, m_used, m_gap, m_ptr;
   logic [W-1:0] m_rx;
   logic         m_rxv;

   uio_bus_arbiter #(.WIDTH(W), .MAX_BURST(MB), .TURN_CYCLES(TC)) dut (
      .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1), .pad_in(pad_in),
      .gnt(gnt), .pad_out(pad_out), .pad_oe(pad_oe), .rx_data(rx_data), .rx_valid(rx_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_own  = -1;
      m_used = 0;
      m_gap  = 0;
      m_ptr  = 0;
      m_rx   = '0;
      m_rxv  = 1'b0;
   endtask

   task automatic model_edge();
      logic idle_now;
      idle_now = (m_own < 0) && (m_gap == 0);
      m_rxv = idle_now;
      if (idle_now) m_rx = pad_in;
      if (m_own >= 0) begin
         m_used++;
         if (!req[m_own] || m_used == MB) begin
            m_ptr = 1 - m_own;
            m_own = -1;
            m_gap = TC;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else if (req != 2'b00) begin
         m_own  = (req == 2'b11) ? m_ptr : (req[1] ? 1 : 0);
         m_used = 0;
      end
   endtask

   task automatic check_outputs();
      logic [1:0]   e_gnt;
      logic [W-1:0] e_oe, e_po;
      e_gnt = (m_own < 0) ? 2'b00 : ((m_own == 1) ? 2'b10 : 2'b01);
      e_oe  = (m_own >= 0) ? '1 : '0;
      e_po  = (m_own == 0) ? data0 : ((m_own == 1) ? data1 : '0);
      chk("gnt", gnt, e_gnt);
      chk("pad_oe", pad_oe, e_oe);
      chk("pad_out", pad_out, e_po);
      chk("rx_data", rx_data, m_rx);
      chk("rx_valid", rx_valid, m_rxv);
      chk("gnt_not_11", (gnt == 2'b11), 1'b0);
   endtask

   task automatic step(input logic [1:0] r, input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [W-1:0] pin);
      @(negedge clk);
      req = r; data0 = d0; data1 = d1; pad_in = pin;
      #1;
      check_outputs();
      @(posedge clk);
      model_edge();
   endtask

   initial begin
      logic [1:0] r;
      rst = 1'b1; req = 2'b00; data0 = '0; data1 = '0; pad_in = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_oe", pad_oe, 8'h00);
      chk("rst_rxv", rx_valid, 1'b0);
      #1 rst = 1'b0;

      // sampling while idle
      step(2'b00, 8'h00, 8'h00, 8'h01);
      step(2'b00, 8'h00, 8'h00, 8'h02);
      step(2'b00, 8'h00, 8'h00, 8'h03);
      // single grant of 3 cycles, pad_in changes must not reach rx_data
      step(2'b01, 8'h5A, 8'h00, 8'h03);
      for (int i = 0; i < 3; i++) step(2'b01, 8'h5A, 8'h11, 8'hE0 + 8'(i));
      for (int i = 0; i < 5; i++) step(2'b00, 8'h5A, 8'h11, 8'h40 + 8'(i));

      // contention held: alternating capped bursts
      for (int i = 0; i < 24; i++) step(2'b11, 8'($urandom), 8'($urandom), 8'($urandom));
      for (int i = 0; i < 4; i++) step(2'b00, 8'h00, 8'h00, 8'h00);

      // single requester hits the cap and re-wins
      for (int i = 0; i < 16; i++) step(2'b10, 8'($urandom), 8'($urandom), 8'($urandom));
      for (int i = 0; i < 4; i++) step(2'b00, 8'h00, 8'h00, 8'h00);

      // owner 0 drops while requester 1 waits
      step(2'b01, 8'hAA, 8'hBB, 8'h00);
      step(2'b11, 8'hAA, 8'hBB, 8'h00);
      for (int i = 0; i < 8; i++) step(2'b10, 8'hAA, 8'hBB, 8'h00);

      // random traffic with held requests
      r = 2'b00;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) r = 2'($urandom_range(0, 3));
         step(r, 8'($urandom), 8'($urandom), 8'($urandom));
      end
      for (int i = 0; i < 6; i++) step(2'b00, 8'h00, 8'h00, 8'h00);

      // asynchronous reset in the middle of a burst
      step(2'b01, 8'hA5, 8'h00, 8'h00);
      step(2'b01, 8'hA5, 8'h00, 8'h00);
      chk("pre_rst_gnt", gnt, 2'b01);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_gnt", gnt, 2'b00);
      chk("async_rst_oe", pad_oe, 8'h00);
      chk("async_rst_out", pad_out, 8'h00);
      model_reset();
      @(posedge clk);
      #2 rst = 1'b0;
      for (int i = 0; i < 3; i++) step(2'b00, 8'hA5, 8'h00, 8'h3C);
      #1;
      chk("post_rst_rx", rx_data, 8'h3C);
      chk("post_rst_rxv", rx_valid, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
